// File: rtl/uartm_rx_bittimer_if.sv
// Bundle of the serial-receive timing signals shared between the bit timer
// and its environment.
//   slave  : the bit timer (consumes line + config, produces timing outputs)
//   master : whoever drives the line/config and watches the timing outputs
// fsm_state exposes the timer's internal state for observation.
interface uartm_rx_bittimer_if;
    logic        RX;
    logic [31:0] uartm_baud;
    logic [31:0] uartm_ctl;
    logic [7:0]  uartm_dw;
    logic [7:0]  uartm_plw;
    logic        rx_bit;
    logic        sample_data_bit;
    logic [7:0]  bit_cnt;
    logic        rx_busy;
    logic        frame_err;
    logic        parity_err;
    logic [2:0]  fsm_state;

    modport master (
        output RX, uartm_baud, uartm_ctl, uartm_dw, uartm_plw,
        input  rx_bit, sample_data_bit, bit_cnt, rx_busy, frame_err, parity_err, fsm_state
    );

    modport slave (
        input  RX, uartm_baud, uartm_ctl, uartm_dw, uartm_plw,
        output rx_bit, sample_data_bit, bit_cnt, rx_busy, frame_err, parity_err, fsm_state
    );
endinterface

// File: rtl/uartm_rx_bittimer.sv
// UART receive bit timer: synchronizes RX, detects the start edge, times each
// bit with a baud counter and flags mid-bit sample points plus stop-bit
// framing and parity errors.
// Optional feature: define UARTM_RX_START_FILTER_EN to reject false starts
// (line back high at the middle of the start bit).
// Handshake: there is no valid/ready pair; sample_data_bit, frame_err and
// parity_err are single-cycle strobes that the consumer must take on the
// cycle they are high, with rx_bit/bit_cnt qualifying sample_data_bit.
module uartm_rx_bittimer (
    input  logic               hclk,
    input  logic               hresetn,
    uartm_rx_bittimer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_n;
    logic        rx_s1, rx_bit, rx_d;
    logic [1:0]  fill;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [15:0] cpb_q, cpb_n;
    logic [7:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  plw_q, plw_n;
    logic        par_en_q, par_en_n;
    logic        par_even_q, par_even_n;
    logic        acc, acc_n;
    logic        frame_err, frame_err_n;
    logic        parity_err, parity_err_n;
    logic        sample;
    logic        start_edge, mid_bit, bit_end;
    logic        unused_cfg;

    // The data-bit count is implied by plw; the upper baud/ctl bits are don't-care.
    assign unused_cfg = ^{bus.uartm_baud[31:16], bus.uartm_ctl[31:4],
                          bus.uartm_ctl[1:0], bus.uartm_dw};

    // Line synchronizer plus edge-detect flop; fill tracks how many stages hold real samples.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rx_s1  <= 1'b1;
            rx_bit <= 1'b1;
            rx_d   <= 1'b1;
            fill   <= 2'd0;
        end else begin
            rx_s1  <= bus.RX;
            rx_bit <= rx_s1;
            rx_d   <= rx_bit;
            if (fill != 2'd3) fill <= fill + 2'd1;
        end
    end

    // The reset value 1 in the chain is not a real line level, so a line that
    // is already low at reset release must not look like a falling edge.
    assign start_edge = (fill == 2'd3) && !rx_bit && rx_d;
    assign mid_bit    = (baud_cnt == {1'b0, cpb_q[15:1]});
    assign bit_end    = (baud_cnt == cpb_q - 16'd1);

    // State and frame registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= IDLE;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 8'd0;
            cpb_q      <= 16'd0;
            plw_q      <= 8'd0;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            acc        <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            cpb_q      <= cpb_n;
            plw_q      <= plw_n;
            par_en_q   <= par_en_n;
            par_even_q <= par_even_n;
            acc        <= acc_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
        end
    end

    // Next-state, counter and strobe logic; configuration is frozen at the start edge.
    always_comb begin
        state_n      = state;
        baud_cnt_n   = bit_end ? 16'd0 : baud_cnt + 16'd1;
        bit_cnt_n    = bit_cnt;
        cpb_n        = cpb_q;
        plw_n        = plw_q;
        par_en_n     = par_en_q;
        par_even_n   = par_even_q;
        acc_n        = acc;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
        sample       = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_n = 16'd0;
                bit_cnt_n  = 8'd0;
                if (start_edge) begin
                    state_n    = START;
                    acc_n      = 1'b0;
                    cpb_n      = bus.uartm_baud[15:0];
                    plw_n      = bus.uartm_plw;
                    par_en_n   = bus.uartm_ctl[2];
                    par_even_n = bus.uartm_ctl[3];
                end
            end
            START: begin
`ifdef UARTM_RX_START_FILTER_EN
                if (mid_bit && rx_bit) begin
                    state_n    = IDLE;
                    baud_cnt_n = 16'd0;
                end else
`endif
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = 8'd1;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    sample = 1'b1;
                    acc_n  = acc ^ rx_bit;
                end
                if (bit_end) begin
                    if (bit_cnt == plw_q - 8'd1) state_n = STOP;
                    else                         bit_cnt_n = bit_cnt + 8'd1;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    state_n      = DONE;
                    bit_cnt_n    = plw_q;
                    frame_err_n  = !rx_bit;
                    parity_err_n = par_en_q && (acc != (par_even_q ? 1'b0 : 1'b1));
                end
            end
            DONE: begin
                state_n    = IDLE;
                bit_cnt_n  = 8'd0;
                baud_cnt_n = 16'd0;
            end
            default: begin
                state_n    = IDLE;
                bit_cnt_n  = 8'd0;
                baud_cnt_n = 16'd0;
            end
        endcase
    end

    assign bus.rx_bit          = rx_bit;
    assign bus.sample_data_bit = sample;
    assign bus.bit_cnt         = bit_cnt;
    assign bus.rx_busy         = (state != IDLE);
    assign bus.frame_err       = frame_err;
    assign bus.parity_err      = parity_err;
    assign bus.fsm_state       = state;
endmodule

// File: tb/tb_uartm_rx_bittimer.sv
// Directed bench for uartm_rx_bittimer: drives serial frames on RX and checks
// the captured mid-bit samples, bit indices and error strobes against
// hand-computed frames.
module tb_uartm_rx_bittimer;
    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    uartm_rx_bittimer_if bus();

    uartm_rx_bittimer dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] cur_cpb  = 16'd16;
    logic [7:0]  mon_plw  = 8'd9;
    logic        aborted  = 1'b0;

    // Captured {bit_cnt, rx_bit} at every sample pulse, and the expected list.
    logic [8:0]  cap_q[$];
    logic [8:0]  exp_q[$];
    int          done_n = 0, ferr_n = 0, ferr_done_n = 0;
    int          perr_n = 0, perr_done_n = 0, idle_after_err_n = 0;
    logic        prev_err = 1'b0;
    int          b_cap, b_done, b_ferr, b_ferr_done, b_perr, b_perr_done, b_idle_err;

    // Monitor: samples DUT outputs on the inactive edge.
    always @(negedge hclk) begin
        if (bus.sample_data_bit) cap_q.push_back({bus.bit_cnt, bus.rx_bit});
        if (bus.bit_cnt == mon_plw) done_n++;
        if (bus.frame_err) begin
            ferr_n++;
            if (bus.bit_cnt == mon_plw) ferr_done_n++;
        end
        if (bus.parity_err) begin
            perr_n++;
            if (bus.bit_cnt == mon_plw) perr_done_n++;
        end
        if (prev_err && !bus.rx_busy) idle_after_err_n++;
        prev_err = bus.frame_err | bus.parity_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] cpb, input logic [31:0] ctl,
                           input logic [7:0] dw, input logic [7:0] plw);
        bus.uartm_baud = {16'hBEEF, cpb};
        bus.uartm_ctl  = ctl;
        bus.uartm_dw   = dw;
        bus.uartm_plw  = plw;
        mon_plw        = plw;
        cur_cpb        = cpb;
    endtask

    task automatic snap();
        b_cap       = cap_q.size();
        b_done      = done_n;
        b_ferr      = ferr_n;
        b_ferr_done = ferr_done_n;
        b_perr      = perr_n;
        b_perr_done = perr_done_n;
        b_idle_err  = idle_after_err_n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.rx_busy && n < 2000) begin
            @(negedge hclk);
            n++;
        end
        repeat (4) @(negedge hclk);
    endtask

    // Start bit, nbits of bits[] LSB first, then the stop level.
    // short_stop ends the stop bit as soon as DONE is seen; abort_at asserts
    // reset when bit_cnt reaches that index; scramble changes config mid-frame.
    task automatic send_frame(input logic [8:0] bits, input int nbits, input logic stop_v,
                              input bit short_stop, input int abort_at, input bit scramble);
        aborted = 1'b0;
        for (int k = 0; k <= nbits; k++) begin
            bus.RX = (k == 0) ? 1'b0 : bits[k-1];
            for (int c = 0; c < int'(cur_cpb); c++) begin
                @(negedge hclk);
                if (abort_at != 0 && bus.bit_cnt == 8'(abort_at)) begin
                    hresetn = 1'b0;
                    bus.RX  = 1'b1;
                    aborted = 1'b1;
                    return;
                end
            end
            if (k == 0 && scramble) begin
                bus.uartm_baud = 32'h0000_0006;
                bus.uartm_plw  = 8'd4;
                bus.uartm_dw   = 8'd3;
                bus.uartm_ctl  = 32'h0000_000C;
            end
        end
        bus.RX = stop_v;
        for (int c = 0; c < int'(cur_cpb); c++) begin
            @(negedge hclk);
            if (short_stop && bus.bit_cnt == mon_plw) return;
        end
        bus.RX = 1'b1;
        wait_idle();
    endtask

    // Compare everything captured since the last snap() against the expected frame(s).
    task automatic check_frame(input string tag, input logic [15:0] exp_bits, input int n_exp,
                               input int per_frame, input int exp_done,
                               input int exp_ferr, input int exp_perr);
        logic [8:0] e;
        check({tag, "_busy"}, 32'(bus.rx_busy), 32'd0);
        check({tag, "_pulses"}, 32'(cap_q.size() - b_cap), 32'(n_exp));
        exp_q.delete();
        for (int i = 0; i < n_exp; i++) exp_q.push_back({8'((i % per_frame) + 1), exp_bits[i]});
        for (int i = 0; i < n_exp; i++) begin
            e = exp_q.pop_front();
            if (b_cap + i < cap_q.size())
                check($sformatf("%s_smp%0d", tag, i), 32'(cap_q[b_cap + i]), 32'(e));
        end
        check({tag, "_done"},      32'(done_n - b_done),           32'(exp_done));
        check({tag, "_ferr"},      32'(ferr_n - b_ferr),           32'(exp_ferr));
        check({tag, "_ferr_done"}, 32'(ferr_done_n - b_ferr_done), 32'(exp_ferr));
        check({tag, "_perr"},      32'(perr_n - b_perr),           32'(exp_perr));
        check({tag, "_perr_done"}, 32'(perr_done_n - b_perr_done), 32'(exp_perr));
        check({tag, "_idle_next"}, 32'(idle_after_err_n - b_idle_err),
              32'((exp_ferr != 0 || exp_perr != 0) ? 1 : 0));
    endtask

    initial begin
        // Reset with the line held low.
        bus.RX = 1'b0;
        set_cfg(16'd16, 32'h0, 8'd8, 8'd9);
        repeat (3) @(negedge hclk);
        check("rst_rx_bit",   32'(bus.rx_bit),          32'd1);
        check("rst_sample",   32'(bus.sample_data_bit), 32'd0);
        check("rst_bit_cnt",  32'(bus.bit_cnt),         32'd0);
        check("rst_busy",     32'(bus.rx_busy),         32'd0);
        check("rst_ferr",     32'(bus.frame_err),       32'd0);
        check("rst_perr",     32'(bus.parity_err),      32'd0);
        check("rst_state",    32'(bus.fsm_state),       32'd0);

        // Line already low at release: no frame.
        hresetn = 1'b1;
        repeat (40) @(negedge hclk);
        check("low_line_busy",   32'(bus.rx_busy),  32'd0);
        check("low_line_pulses", 32'(cap_q.size()), 32'd0);
        bus.RX = 1'b1;
        repeat (8) @(negedge hclk);

        // 0xA5, config changed while the frame is in progress.
        snap();
        send_frame(9'h0A5, 8, 1'b1, 1'b0, 0, 1'b1);
        set_cfg(16'd16, 32'h0, 8'd8, 8'd9);
        check_frame("a5", 16'h00A5, 8, 8, 1, 0, 0);

        // Even parity, 0x01: parity bit 0 is wrong, 1 is right.
        set_cfg(16'd16, 32'h0000_000C, 8'd8, 8'd10);
        snap();
        send_frame({1'b0, 8'h01}, 9, 1'b1, 1'b0, 0, 1'b0);
        check_frame("par0", 16'h0001, 9, 9, 1, 0, 1);
        snap();
        send_frame({1'b1, 8'h01}, 9, 1'b1, 1'b0, 0, 1'b0);
        check_frame("par1", 16'h0101, 9, 9, 1, 0, 0);

        // Stop bit driven low.
        set_cfg(16'd16, 32'h0, 8'd8, 8'd9);
        snap();
        send_frame(9'h05A, 8, 1'b0, 1'b0, 0, 1'b0);
        check_frame("ferr", 16'h005A, 8, 8, 1, 1, 0);

        // 3-cycle low glitch on the idle line.
        snap();
        bus.RX = 1'b0;
        repeat (3) @(negedge hclk);
        bus.RX = 1'b1;
`ifdef UARTM_RX_START_FILTER_EN
        repeat (40) @(negedge hclk);
        check_frame("glitch", 16'h0000, 0, 8, 0, 0, 0);
`else
        repeat (2) @(negedge hclk);
        wait_idle();
        check_frame("glitch", 16'h00FF, 8, 8, 1, 0, 0);
`endif

        // Reset asserted at bit_cnt 4, then a clean 0x3C.
        snap();
        send_frame(9'h03C, 8, 1'b1, 1'b0, 4, 1'b0);
        check("abort_reached", 32'(aborted), 32'd1);
        #1;
        check("abort_busy",    32'(bus.rx_busy),         32'd0);
        check("abort_bit_cnt", 32'(bus.bit_cnt),         32'd0);
        check("abort_sample",  32'(bus.sample_data_bit), 32'd0);
        check("abort_errs",    32'({bus.frame_err, bus.parity_err}), 32'd0);
        repeat (3) @(negedge hclk);
        check("abort_no_done", 32'(done_n - b_done), 32'd0);
        hresetn = 1'b1;
        repeat (6) @(negedge hclk);
        snap();
        send_frame(9'h03C, 8, 1'b1, 1'b0, 0, 1'b0);
        check_frame("post_rst", 16'h003C, 8, 8, 1, 0, 0);

        // Back-to-back 0x55 then 0xAA.
        snap();
        send_frame(9'h055, 8, 1'b1, 1'b1, 0, 1'b0);
        send_frame(9'h0AA, 8, 1'b1, 1'b0, 0, 1'b0);
        check_frame("b2b", 16'hAA55, 16, 8, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
